twi_slave: RTL and testbench

TWI_SLAVE -- requirements
Module: twi_slave

---
 rtl/twi_slave.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_twi_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twi_slave.sv
// ---------------------------------------------------------------------------
// twi_slave
//   Two-wire (I2C-style) bus responder with an 8 x 8-bit register file.
//   A master writes a register pointer followed by data bytes, or reads
//   bytes back starting from the retained pointer. The pointer auto-
//   increments modulo 8 after each written byte and after each ACKed read.
//
// Parameters
//   SLV_ADDR     7-bit bus address this responder answers to
//
// Ports
//   CLK_I        system clock, all logic on its rising edge
//   RST_N_I      asynchronous active-low reset
//   TWI_SCL_I    bus clock from the master (asynchronous to CLK_I)
//   TWI_SDA_I    bus data (asynchronous to CLK_I)
//   TWI_SDA_OEN  SDA drive control: 0 pulls SDA low, 1 releases it
//   WR_VLD       one-cycle pulse when a received byte is committed
//   WR_ADDR      register index of the committed byte
//   WR_DATA      committed byte
//   RD_ADDR      local read index into the register file
//   RD_DATA      register content at RD_ADDR, one cycle latency
//   BUSY         high from a START to the matching STOP
//
// States
//   IDLE      | not addressed; bus ignored until the next START
//   ADDR      | shifting in address byte + R/W bit
//   ADDR_ACK  | acknowledging our address
//   PTR       | shifting in register pointer byte
//   PTR_ACK   | acknowledging the pointer byte
//   WDATA     | shifting in a write data byte
//   WDATA_ACK | acknowledging a write data byte
//   RDATA     | driving a read data byte MSB first
//   RDATA_ACK | SDA released, sampling master ACK/NACK
// ---------------------------------------------------------------------------
module twi_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       CLK_I,
    input  logic       RST_N_I,
    input  logic       TWI_SCL_I,
    input  logic       TWI_SDA_I,
    output logic       TWI_SDA_OEN,
    output logic       WR_VLD,
    output logic [2:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    input  logic [2:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic       BUSY
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // -----------------------------------------------------------------------
    // Bus synchronizers and history stage. Reset value 1 matches an idle bus
    // so leaving reset never fabricates an edge or a START/STOP.
    // -----------------------------------------------------------------------
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], TWI_SCL_I};
            sda_sync <= {sda_sync[0], TWI_SDA_I};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    logic scl_now;
    logic sda_now;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_now   = scl_sync[1];
    assign sda_now   = sda_sync[1];
    assign scl_rise  = scl_now & ~scl_hist;
    assign scl_fall  = ~scl_now & scl_hist;
    // SCL must be high on both sides of the SDA transition
    assign start_det = scl_now & scl_hist & sda_hist & ~sda_now;
    assign stop_det  = scl_now & scl_hist & ~sda_hist & sda_now;

    // -----------------------------------------------------------------------
    // Protocol state
    // -----------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic       phase;
    logic       phase_nxt;
    logic       rw;
    logic       rw_nxt;
    logic       oen;
    logic       oen_nxt;
    logic       busy;
    logic       busy_nxt;
    logic       wr_en;

    logic [7:0] regs [8];

    logic [7:0] rx_byte;
    logic [2:0] ptr_inc;
    logic       last_bit;

    assign rx_byte  = {shreg[6:0], sda_now};
    assign ptr_inc  = ptr + 3'd1;
    assign last_bit = (bit_cnt == 3'd7);

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            phase   <= 1'b0;
            rw      <= 1'b0;
            oen     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            ptr     <= ptr_nxt;
            phase   <= phase_nxt;
            rw      <= rw_nxt;
            oen     <= oen_nxt;
            busy    <= busy_nxt;
        end
    end

    // 'phase' is reused per state:
    //   *_ACK (write side): 0 = waiting for the fall that starts the ACK,
    //                       1 = ACK driven, next fall ends it
    //   RDATA:              1 = eighth bit clocked, next fall releases SDA
    //   RDATA_ACK:          1 = master ACK sampled, next fall loads next byte
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        phase_nxt   = phase;
        rw_nxt      = rw;
        oen_nxt     = oen;
        busy_nxt    = busy;
        wr_en       = 1'b0;

        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            oen_nxt     = 1'b1;
            busy_nxt    = 1'b1;
        end else if (stop_det) begin
            state_nxt = IDLE;
            phase_nxt = 1'b0;
            oen_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oen_nxt = 1'b1;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == SLV_ADDR) begin
                                rw_nxt    = rx_byte[0];
                                phase_nxt = 1'b0;
                                state_nxt = ADDR_ACK;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end

                PTR: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            ptr_nxt   = rx_byte[2:0];
                            phase_nxt = 1'b0;
                            state_nxt = PTR_ACK;
                        end
                    end
                end

                WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            // commit uses the current ptr, then advance it
                            wr_en     = 1'b1;
                            ptr_nxt   = ptr_inc;
                            phase_nxt = 1'b0;
                            state_nxt = WDATA_ACK;
                        end
                    end
                end

                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            oen_nxt   = 1'b0;
                            phase_nxt = 1'b1;
                        end else begin
                            phase_nxt   = 1'b0;
                            bit_cnt_nxt = '0;
                            oen_nxt     = 1'b1;
                            if (state == ADDR_ACK && rw) begin
                                // first read bit goes out on the same fall
                                shreg_nxt = regs[ptr];
                                oen_nxt   = regs[ptr][7];
                                state_nxt = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_nxt = PTR;
                            end else begin
                                state_nxt = WDATA;
                            end
                        end
                    end
                end

                RDATA: begin
                    // shift on the rise so shreg[7] holds the next bit to drive
                    if (scl_rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            phase_nxt = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (phase) begin
                            phase_nxt = 1'b0;
                            oen_nxt   = 1'b1;
                            state_nxt = RDATA_ACK;
                        end else begin
                            oen_nxt = shreg[7];
                        end
                    end
                end

                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_now) begin
                            state_nxt = IDLE;
                        end else begin
                            phase_nxt = 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = '0;
                        ptr_nxt     = ptr_inc;
                        shreg_nxt   = regs[ptr_inc];
                        oen_nxt     = regs[ptr_inc][7];
                        state_nxt   = RDATA;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    oen_nxt   = 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Register file and local ports. The read port samples the array before
    // a same-cycle write lands, so a colliding read sees old data first.
    // -----------------------------------------------------------------------
    logic       wr_vld_q;
    logic [2:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] rd_data_q;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[ptr] <= rx_byte;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
        end else begin
            wr_vld_q  <= wr_en;
            rd_data_q <= regs[RD_ADDR];
            if (wr_en) begin
                wr_addr_q <= ptr;
                wr_data_q <= rx_byte;
            end
        end
    end

    assign TWI_SDA_OEN = oen;
    assign WR_VLD      = wr_vld_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
    assign RD_DATA     = rd_data_q;
    assign BUSY        = busy;

endmodule

// File: tb/tb_twi_slave.sv
// ---------------------------------------------------------------------------
// tb_twi_slave
//   Bit-banged bus master driving twi_slave, checked against a register-file
//   model (array of 8 bytes plus a pointer) and a log of expected commits.
// ---------------------------------------------------------------------------
module tb_twi_slave;

    localparam int Q = 100;   // quarter of a bus bit period

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oen;
    logic       wr_vld;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    assign sda_bus = sda_m & sda_oen;

    twi_slave #(.SLV_ADDR(7'h50)) dut (
        .CLK_I      (clk),
        .RST_N_I    (rst_n),
        .TWI_SCL_I  (scl),
        .TWI_SDA_I  (sda_bus),
        .TWI_SDA_OEN(sda_oen),
        .WR_VLD     (wr_vld),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .RD_ADDR    (rd_addr),
        .RD_DATA    (rd_data),
        .BUSY       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // reference model
    logic [7:0]  mregs [8];
    int          mptr;
    logic [10:0] exp_q [$];
    logic [10:0] got_q [$];
    logic [7:0]  wbuf  [4];

    // commit monitor, sampled on the falling clock edge
    logic       vld_d;
    logic [7:0] rd_at_pulse;
    logic [7:0] rd_after_pulse;

    always @(negedge clk) begin
        vld_d <= wr_vld;
        if (wr_vld) begin
            got_q.push_back({wr_addr, wr_data});
            rd_at_pulse <= rd_data;
        end
        if (vld_d) rd_after_pulse <= rd_data;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic bit_in(output logic v);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; v = sda_bus; #Q; scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            bit_in(v);
            b[i] = v;
        end
        bit_out(nack);
    endtask

    task automatic start_cond;
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic stop_cond;
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    // address + pointer + n data bytes from wbuf; caller issues START/STOP
    task automatic do_write(input logic [7:0] praw, input int n);
        logic ack;
        check("busy_in_txn", busy, 1);
        send_byte(8'hA0, ack);
        check("addr_w_ack", ack, 0);
        check("sda_rel_addr", sda_oen, 1);
        send_byte(praw, ack);
        check("ptr_ack", ack, 0);
        check("sda_rel_ptr", sda_oen, 1);
        mptr = praw % 8;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            check("data_ack", ack, 0);
            check("sda_rel_data", sda_oen, 1);
            mregs[mptr] = wbuf[i];
            exp_q.push_back({3'(mptr), wbuf[i]});
            mptr = (mptr + 1) % 8;
        end
    endtask

    // read address + n bytes, last one NACKed; caller issues START/STOP
    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] b;
        send_byte(8'hA1, ack);
        check("addr_r_ack", ack, 0);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, k == n - 1);
            check("rd_byte", b, mregs[mptr]);
            if (k != n - 1) mptr = (mptr + 1) % 8;
        end
        check("sda_rel_nack", sda_oen, 1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #20;
            check(tag, rd_data, mregs[i]);
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] old_v;
        logic [7:0] new_v;
        logic [7:0] praw;
        int         nw;
        int         nr;

        rst_n   = 1'b0;
        scl     = 1'b1;
        sda_m   = 1'b1;
        rd_addr = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mptr = 0;

        #100;
        check("rst_oen", sda_oen, 1);
        check("rst_wr_vld", wr_vld, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #(2*Q);

        // write 0x5A, 0xC3 starting at register 3
        start_cond;
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        do_write(8'h03, 2);
        stop_cond;
        check("busy_after_stop", busy, 0);
        compare_log("wr_log_basic");
        rd_addr = 3'd4;
        #20;
        check("rd_reg4", rd_data, 8'hC3);

        // pointer wrap 7 -> 0
        start_cond;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h07, 2);
        stop_cond;
        compare_log("wr_log_wrap");
        rd_addr = 3'd7;
        #20;
        check("rd_reg7", rd_data, 8'h11);
        rd_addr = 3'd0;
        #20;
        check("rd_reg0", rd_data, 8'h22);

        // set pointer, repeated START, read two bytes
        start_cond;
        do_write(8'h03, 0);
        start_cond;
        do_read(2);
        stop_cond;
        compare_log("wr_log_rdback");

        // foreign address: no ACK, no commit, BUSY until STOP
        start_cond;
        send_byte(8'hA2, ack);
        check("nomatch_ack", ack, 1);
        check("nomatch_busy", busy, 1);
        send_byte(8'h55, ack);
        check("nomatch_ignored", ack, 1);
        stop_cond;
        check("nomatch_busy_stop", busy, 0);
        compare_log("wr_log_nomatch");

        // STOP in the middle of a data byte
        start_cond;
        do_write(8'h01, 0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
        stop_cond;
        check("midstop_busy", busy, 0);
        scl = 1'b0; #Q;
        send_byte(8'hA0, ack);
        check("midstop_idle", ack, 1);
        stop_cond;
        compare_log("wr_log_midstop");
        check_regs("regs_midstop");

        // read/write collision on the local read port
        old_v = mregs[5];
        new_v = 8'($urandom);
        if (new_v == old_v) new_v = ~old_v;
        rd_addr = 3'd5;
        start_cond;
        wbuf[0] = new_v;
        do_write(8'h05, 1);
        stop_cond;
        compare_log("wr_log_collide");
        check("collide_old", rd_at_pulse, old_v);
        check("collide_new", rd_after_pulse, new_v);

        // randomized write/read transactions
        for (int it = 0; it < 5; it++) begin
            nw   = int'($urandom_range(1, 4));
            nr   = int'($urandom_range(1, 4));
            praw = 8'($urandom);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            start_cond;
            if (it != 1 && it != 3) begin
                do_write(praw, nw);
                start_cond;
            end
            do_read(nr);
            stop_cond;
            compare_log("wr_log_rand");
            check_regs("regs_rand");
        end

        // reset in the 4th bit of a data byte
        start_cond;
        do_write(8'h02, 0);
        b = 8'h96;
        bit_out(b[7]); bit_out(b[6]); bit_out(b[5]);
        sda_m = b[4]; #Q; scl = 1'b1; #Q;
        rst_n = 1'b0;
        #1;
        check("rst_mid_oen", sda_oen, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rd", rd_data, 0);
        #(Q-1);
        scl = 1'b0; #Q;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mptr = 0;
        bit_out(b[3]); bit_out(b[2]); bit_out(b[1]); bit_out(b[0]);
        bit_in(ack);
        check("rst_ignore_ack", ack, 1);
        stop_cond;
        compare_log("wr_log_rst");
        check_regs("regs_after_rst");

        // fresh transaction after reset
        start_cond;
        wbuf[0] = 8'h3C; wbuf[1] = 8'hE7;
        do_write(8'h06, 2);
        start_cond;
        do_read(3);
        stop_cond;
        compare_log("wr_log_post_rst");
        check_regs("regs_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
